// File: rtl/crossbar_pkg.sv
// Shared types and defaults for the accumulator crossbar scheduler.
// Bank geometry defaults live here so the arbiter and the scheduler agree on them.
package crossbar_pkg;
    localparam int CB_BANK_COUNT = 256;
    localparam int CB_BANK_W     = $clog2(CB_BANK_COUNT);

    typedef enum logic [1:0] {
        BW2        = 2'b00,
        BW4        = 2'b01,
        BW8        = 2'b10,
        BW_ILLEGAL = 2'b11
    } bitwidth_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_e;
endpackage

// File: rtl/bank_conflict_arbiter.sv
// First-fit bank arbiter: lower lanes win, and each bank is granted to at most one lane.
// Purely combinational; the walk over lanes is ordered, so priority follows lane index.
module bank_conflict_arbiter
    import crossbar_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int BANK_COUNT = CB_BANK_COUNT,
    parameter int BANK_W     = $clog2(BANK_COUNT)
) (
    input  logic [LANES-1:0]        i_pending,
    input  logic [LANES*BANK_W-1:0] i_bank_id,
    output logic [LANES-1:0]        o_grant
);
    logic [BANK_COUNT-1:0] w_claimed;

    always_comb begin
        w_claimed = '0;
        o_grant   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_pending[i] && !w_claimed[i_bank_id[i*BANK_W +: BANK_W]]) begin
                o_grant[i]                               = 1'b1;
                w_claimed[i_bank_id[i*BANK_W +: BANK_W]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/crossbar_scheduler.sv
// Drains one product batch per accept through the crossbar, issuing a conflict-free lane
// subset each cycle and stalling the multiplier array until every lane has gone out.
module crossbar_scheduler
    import crossbar_pkg::*;
#(
    parameter int LANES      = 16,
    parameter int BANK_COUNT = CB_BANK_COUNT,
    parameter int BANK_W     = $clog2(BANK_COUNT),
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_mask,
    input  logic [LANES*BANK_W-1:0] in_bank_id,
    input  logic [1:0]              in_bitwidth,
    output logic                    issue_valid,
    output logic [LANES-1:0]        issue_mask,
    output logic [1:0]              issue_bitwidth,
    output logic                    crossbar_stall,
    output logic                    batch_done,
    output logic                    busy,
    output logic [CNT_W-1:0]        conflict_cycles,
    output logic                    illegal_cfg,
    input  logic                    clear_stats
);
    sched_state_e            r_state, w_state_nxt;
    logic [LANES-1:0]        r_pending, w_grant, w_left;
    logic [LANES*BANK_W-1:0] r_banks;
    logic [1:0]              r_bw;
    logic [CNT_W-1:0]        r_conflict;
    logic                    r_illegal;
    logic                    w_busy, w_stall, w_done, w_accept, w_empty;

    bank_conflict_arbiter #(
        .LANES      (LANES),
        .BANK_COUNT (BANK_COUNT),
        .BANK_W     (BANK_W)
    ) u_arb (
        .i_pending (r_pending),
        .i_bank_id (r_banks),
        .o_grant   (w_grant)
    );

    assign w_busy   = (r_state == BUSY);
    assign w_left   = r_pending & ~w_grant;
    assign w_stall  = w_busy & (|w_left);
    assign w_done   = w_busy & ~w_stall;
    assign in_ready = (r_state == IDLE) | w_done;
    assign w_accept = in_valid & in_ready;
    // Empty or illegal batches still take one BUSY cycle so the handshake stays uniform.
    assign w_empty  = (in_lane_mask == '0) || (in_bitwidth == BW_ILLEGAL);

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)    w_state_nxt = BUSY;
        else if (w_done) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_banks   <= '0;
            r_bw      <= '0;
        end else if (w_accept) begin
            r_pending <= w_empty ? '0 : in_lane_mask;
            r_banks   <= in_bank_id;
            r_bw      <= in_bitwidth;
        end else begin
            r_pending <= w_left;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict <= '0;
            r_illegal  <= 1'b0;
        end else begin
            if (clear_stats)                r_conflict <= '0;
            else if (w_stall && ~&r_conflict) r_conflict <= r_conflict + CNT_W'(1);
            // A same-cycle illegal accept outranks the clear.
            if (w_accept && in_bitwidth == BW_ILLEGAL) r_illegal <= 1'b1;
            else if (clear_stats)                      r_illegal <= 1'b0;
        end
    end

    assign issue_mask      = w_grant;
    assign issue_valid     = |w_grant;
    assign issue_bitwidth  = r_bw;
    assign crossbar_stall  = w_stall;
    assign batch_done      = w_done;
    assign busy            = w_busy;
    assign conflict_cycles = r_conflict;
    assign illegal_cfg     = r_illegal;
endmodule

// File: tb/tb_crossbar_scheduler.sv
// Randomized and directed bench for crossbar_scheduler against a lane-list reference model.
module tb_crossbar_scheduler;
    localparam int LANES  = 16;
    localparam int BANK_W = 8;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_mask = '0;
    logic [LANES*BANK_W-1:0] in_bank_id = '0;
    logic [1:0]              in_bitwidth = '0;
    logic                    issue_valid;
    logic [LANES-1:0]        issue_mask;
    logic [1:0]              issue_bitwidth;
    logic                    crossbar_stall;
    logic                    batch_done;
    logic                    busy;
    logic [CNT_W-1:0]        conflict_cycles;
    logic                    illegal_cfg;
    logic                    clear_stats = 1'b0;

    int checks = 0;
    int failures = 0;

    crossbar_scheduler #(.LANES(LANES), .BANK_COUNT(256), .BANK_W(BANK_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_mask(in_lane_mask), .in_bank_id(in_bank_id), .in_bitwidth(in_bitwidth),
        .issue_valid(issue_valid), .issue_mask(issue_mask), .issue_bitwidth(issue_bitwidth),
        .crossbar_stall(crossbar_stall), .batch_done(batch_done), .busy(busy),
        .conflict_cycles(conflict_cycles), .illegal_cfg(illegal_cfg), .clear_stats(clear_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the batch is a list of (lane, bank) pairs still owed to the crossbar.
    bit         m_busy = 0;
    bit [15:0]  m_pend = 0;
    int         m_bank [LANES];
    int         m_bw = 0;
    int         m_cc = 0;
    bit         m_ill = 0;

    function automatic bit [15:0] first_fit(input bit [15:0] p, input int b [LANES]);
        int used [$];
        int hits [$];
        bit [15:0] g = 0;
        for (int i = 0; i < LANES; i++) begin
            if (p[i]) begin
                hits = used.find with (item == b[i]);
                if (hits.size() == 0) begin
                    g[i] = 1'b1;
                    used.push_back(b[i]);
                end
            end
        end
        return g;
    endfunction

    always @(negedge clk) begin
        bit [15:0] g, left;
        bit e_stall, e_done, e_ready, acc;
        if (reset) begin
            m_busy = 0; m_pend = 0; m_bw = 0; m_cc = 0; m_ill = 0;
        end
        g       = m_busy ? first_fit(m_pend, m_bank) : 16'h0;
        left    = m_pend & ~g;
        e_stall = m_busy && left != 0;
        e_done  = m_busy && left == 0;
        e_ready = !m_busy || e_done;
        chk("issue_mask", issue_mask, g);
        chk("issue_valid", issue_valid, g != 0);
        chk("crossbar_stall", crossbar_stall, e_stall);
        chk("batch_done", batch_done, e_done);
        chk("in_ready", in_ready, e_ready);
        chk("busy", busy, m_busy);
        chk("issue_bitwidth", issue_bitwidth, m_bw);
        chk("conflict_cycles", conflict_cycles, m_cc);
        chk("illegal_cfg", illegal_cfg, m_ill);
        if (!reset) begin
            acc = in_valid && e_ready;
            if (clear_stats) m_cc = 0;
            else if (e_stall && m_cc != 65535) m_cc++;
            if (acc && in_bitwidth == 2'b11) m_ill = 1;
            else if (clear_stats) m_ill = 0;
            if (acc) begin
                m_busy = 1;
                m_pend = (in_lane_mask == 0 || in_bitwidth == 2'b11) ? 16'h0 : in_lane_mask;
                m_bw   = in_bitwidth;
                for (int i = 0; i < LANES; i++) m_bank[i] = in_bank_id[i*BANK_W +: BANK_W];
            end else begin
                m_pend = left;
                if (e_done) m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a batch from an IDLE cycle; returns positioned in the first BUSY cycle.
    task automatic go(input logic [15:0] mask, input logic [LANES*BANK_W-1:0] banks,
                      input logic [1:0] bw);
        in_valid = 1'b1; in_lane_mask = mask; in_bank_id = banks; in_bitwidth = bw;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [LANES*BANK_W-1:0] banks_distinct();
        logic [LANES*BANK_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*BANK_W +: BANK_W] = BANK_W'(i);
        return v;
    endfunction

    function automatic logic [LANES*BANK_W-1:0] banks_all(input int b);
        logic [LANES*BANK_W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*BANK_W +: BANK_W] = BANK_W'(b);
        return v;
    endfunction

    initial begin
        logic [LANES*BANK_W-1:0] bk;
        logic [15:0] one;
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset issue_mask", issue_mask, 0);
        chk("reset conflict", conflict_cycles, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        go(16'hFFFF, banks_distinct(), 2'b10);
        chk("distinct issue_mask", issue_mask, 16'hFFFF);
        chk("distinct batch_done", batch_done, 1);
        chk("distinct stall", crossbar_stall, 0);
        chk("distinct bitwidth", issue_bitwidth, 2'b10);
        tick();
        chk("distinct conflict", conflict_cycles, 0);

        go(16'hFFFF, banks_all(7), 2'b00);
        for (int k = 0; k < 16; k++) begin
            one = 16'h1 << k;
            chk("bank7 issue_mask", issue_mask, one);
            chk("bank7 stall", crossbar_stall, k < 15);
            chk("bank7 done", batch_done, k == 15);
            tick();
        end
        chk("bank7 conflict", conflict_cycles, 15);

        bk = '0;
        bk[0*BANK_W +: BANK_W] = 8'd3; bk[1*BANK_W +: BANK_W] = 8'd3;
        bk[2*BANK_W +: BANK_W] = 8'd5; bk[3*BANK_W +: BANK_W] = 8'd5;
        go(16'h000F, bk, 2'b01);
        chk("mixed c1 mask", issue_mask, 16'h0005);
        chk("mixed c1 done", batch_done, 0);
        tick();
        chk("mixed c2 mask", issue_mask, 16'h000A);
        chk("mixed c2 done", batch_done, 1);
        tick();

        go(16'h0000, banks_distinct(), 2'b10);
        chk("empty issue_valid", issue_valid, 0);
        chk("empty done", batch_done, 1);
        tick();
        go(16'hFFFF, banks_distinct(), 2'b11);
        chk("illegal issue_valid", issue_valid, 0);
        chk("illegal done", batch_done, 1);
        chk("illegal cfg", illegal_cfg, 1);
        tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("clear illegal", illegal_cfg, 0);
        chk("clear conflict", conflict_cycles, 0);

        go(16'hFFFF, banks_all(7), 2'b00);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset issue_mask", issue_mask, 0);
        chk("midreset in_ready", in_ready, 1);
        chk("midreset done", batch_done, 0);
        tick();
        reset = 1'b0;
        tick();
        go(16'h00F0, banks_distinct(), 2'b01);
        chk("postreset mask", issue_mask, 16'h00F0);
        chk("postreset done", batch_done, 1);
        tick();

        in_valid = 1'b1; in_lane_mask = 16'hFFFF; in_bank_id = banks_distinct(); in_bitwidth = 2'b10;
        tick();
        chk("b2b first valid", issue_valid, 1);
        chk("b2b first ready", in_ready, 1);
        in_lane_mask = 16'h0F0F; in_bitwidth = 2'b00;
        tick();
        in_valid = 1'b0;
        chk("b2b busy", busy, 1);
        chk("b2b second mask", issue_mask, 16'h0F0F);
        chk("b2b second bw", issue_bitwidth, 2'b00);
        tick();

        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            in_lane_mask = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
            in_bitwidth = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            clear_stats = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < LANES; i++)
                in_bank_id[i*BANK_W +: BANK_W] = ($urandom_range(0, 3) == 0) ?
                    BANK_W'($urandom) : BANK_W'($urandom_range(0, 5));
            tick();
        end
        in_valid = 1'b0; clear_stats = 1'b0;
        repeat (20) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
